dfr_batch_controller: RTL

//  Sequencer for the hybrid DFR datapath. Runs a batch of N samples through reservoir warm-up,
//  per-sample reservoir fill and readout matrix multiply. Adds the following over the

---
 rtl/dfr_pkg.sv | 24 ++
 rtl/dfr_stage_watchdog.sv | 35 +++
 rtl/dfr_batch_controller.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/dfr_pkg.sv
// Shared types and constants for the DFR batch sequencer.
package dfr_pkg;

   localparam int unsigned DFR_STATE_W         = 4;
   localparam int unsigned DFR_TIMEOUT_DEFAULT = 1000000;

   typedef enum logic [DFR_STATE_W-1:0] {
      ST_IDLE     = 4'd0,
      ST_RST      = 4'd1,
      ST_INIT     = 4'd2,
      ST_RUN      = 4'd3,
      ST_MM_START = 4'd4,
      ST_MM_WAIT  = 4'd5,
      ST_NEXT     = 4'd6,
      ST_DONE     = 4'd7,
      ST_ERR      = 4'd8
   } dfr_batch_state_t;

   // States that wait on a core busy flag and are guarded by the watchdog.
   function automatic logic is_wait_state(input dfr_batch_state_t s);
      return (s == ST_INIT) || (s == ST_RUN) || (s == ST_MM_WAIT);
   endfunction

endpackage

// File: rtl/dfr_stage_watchdog.sv
// Per-stage cycle watchdog: expired_o rises during the limit_i-th enabled cycle after a clear.
module dfr_stage_watchdog #(
   parameter int unsigned TIMEOUT_WIDTH = 20
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear_i,
   input  logic                     enable_i,
   input  logic [TIMEOUT_WIDTH-1:0] limit_i,
   output logic                     expired_o
);

   logic [TIMEOUT_WIDTH-1:0] count_q;
   logic [TIMEOUT_WIDTH-1:0] count_inc;
   logic                     expired_q;

   assign count_inc = count_q + TIMEOUT_WIDTH'(1);

   // count_q holds the 1-based index of the current cycle, so expiry is flagged one edge early.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q   <= '0;
         expired_q <= 1'b0;
      end else if (clear_i) begin
         count_q   <= TIMEOUT_WIDTH'(1);
         expired_q <= 1'b0;
      end else if (enable_i && !expired_q) begin
         count_q   <= count_inc;
         expired_q <= (count_inc == limit_i);
      end
   end

   assign expired_o = expired_q;

endmodule

// File: rtl/dfr_batch_controller.sv
// Batch sequencer for the hybrid DFR datapath: warm-up, per-sample fill and readout multiply,
// with continuous mode, abort, stage watchdog and sticky error.
module dfr_batch_controller
   import dfr_pkg::*;
#(
   parameter int unsigned SAMPLE_CNT_WIDTH = 16,
   parameter int unsigned TIMEOUT_WIDTH    = 20,
   parameter int unsigned TIMEOUT_CYCLES   = DFR_TIMEOUT_DEFAULT
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic                        abort,
   input  logic                        mode_continuous,
   input  logic [SAMPLE_CNT_WIDTH-1:0] num_samples,
   input  logic                        reservoir_init_busy,
   input  logic                        reservoir_busy,
   input  logic                        reservoir_filled,
   input  logic                        matrix_multiply_busy,
   output logic                        busy,
   output logic                        reservoir_rst,
   output logic                        reservoir_en,
   output logic                        reservoir_history_en,
   output logic                        matrix_multiply_rst,
   output logic                        matrix_multiply_start,
   output logic                        sample_cntr_rst,
   output logic                        dfr_done,
   output logic                        error,
   output logic [SAMPLE_CNT_WIDTH-1:0] sample_index,
   output logic [DFR_STATE_W-1:0]      state_o
);

   dfr_batch_state_t            state_q, state_d;
   logic [SAMPLE_CNT_WIDTH-1:0] n_q, n_d;
   logic [SAMPLE_CNT_WIDTH-1:0] sample_index_q, sample_index_d;
   logic                        error_q, error_d;
   logic                        entered_q;
   logic                        busy_q;
   logic                        core_rst_q;
   logic                        reservoir_en_q;
   logic                        history_en_q;
   logic                        mm_start_q;
   logic                        cntr_rst_q;
   logic                        done_q;

   logic                        core_rst_c;
   logic                        done_c;
   logic                        start_ok_c;
   logic                        last_sample_c;
   logic                        wd_clear_c;
   logic                        wd_enable_c;
   logic                        wd_expired;

   assign start_ok_c    = start || ((state_q == ST_DONE) && mode_continuous);
   assign last_sample_c = (sample_index_q == (n_q - SAMPLE_CNT_WIDTH'(1)));
   assign wd_clear_c    = (state_d != state_q);
   assign wd_enable_c   = is_wait_state(state_q);

   dfr_stage_watchdog #(
      .TIMEOUT_WIDTH (TIMEOUT_WIDTH)
   ) u_watchdog (
      .clk       (clk),
      .rst       (rst),
      .clear_i   (wd_clear_c),
      .enable_i  (wd_enable_c),
      .limit_i   (TIMEOUT_WIDTH'(TIMEOUT_CYCLES)),
      .expired_o (wd_expired)
   );

   // Next-state logic; abort overrides everything, timeout overrides stage progress.
   always_comb begin
      state_d        = state_q;
      n_d            = n_q;
      sample_index_d = sample_index_q;
      error_d        = error_q;
      core_rst_c     = 1'b0;
      done_c         = 1'b0;

      if (abort && (state_q != ST_IDLE)) begin
         state_d    = ST_IDLE;
         core_rst_c = 1'b1;
      end else if (is_wait_state(state_q) && wd_expired) begin
         state_d    = ST_ERR;
         error_d    = 1'b1;
         core_rst_c = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
               if (start_ok_c) begin
                  n_d            = num_samples;
                  error_d        = 1'b0;
                  sample_index_d = '0;
                  if (num_samples == '0) begin
                     state_d = ST_DONE;
                     done_c  = 1'b1;
                  end else begin
                     state_d = ST_RST;
                  end
               end
            end
            ST_RST:      state_d = ST_INIT;
            ST_INIT:     if (!entered_q && !reservoir_init_busy) state_d = ST_RUN;
            ST_RUN:      if (!entered_q && !reservoir_busy) state_d = ST_MM_START;
            ST_MM_START: state_d = ST_MM_WAIT;
            ST_MM_WAIT:  if (!entered_q && !matrix_multiply_busy) state_d = ST_NEXT;
            ST_NEXT: begin
               if (last_sample_c) begin
                  state_d = ST_DONE;
                  done_c  = 1'b1;
               end else begin
                  sample_index_d = sample_index_q + SAMPLE_CNT_WIDTH'(1);
                  state_d        = ST_RUN;
               end
            end
            default:     state_d = ST_IDLE;
         endcase
      end
   end

   // State and all outputs registered off the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         n_q            <= '0;
         sample_index_q <= '0;
         error_q        <= 1'b0;
         entered_q      <= 1'b0;
         busy_q         <= 1'b0;
         core_rst_q     <= 1'b0;
         reservoir_en_q <= 1'b0;
         history_en_q   <= 1'b0;
         mm_start_q     <= 1'b0;
         cntr_rst_q     <= 1'b0;
         done_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         n_q            <= n_d;
         sample_index_q <= sample_index_d;
         error_q        <= error_d;
         entered_q      <= (state_d != state_q);
         busy_q         <= !((state_d == ST_IDLE) || (state_d == ST_DONE) || (state_d == ST_ERR));
         core_rst_q     <= core_rst_c || (state_d == ST_RST);
         reservoir_en_q <= (state_d == ST_INIT) || (state_d == ST_RUN);
         history_en_q   <= (state_d == ST_RUN) && reservoir_filled;
         mm_start_q     <= (state_d == ST_MM_START);
         cntr_rst_q     <= (state_d == ST_RST) || (state_d == ST_NEXT);
         done_q         <= done_c;
      end
   end

   assign busy                  = busy_q;
   assign reservoir_rst         = core_rst_q;
   assign matrix_multiply_rst   = core_rst_q;
   assign reservoir_en          = reservoir_en_q;
   assign reservoir_history_en  = history_en_q;
   assign matrix_multiply_start = mm_start_q;
   assign sample_cntr_rst       = cntr_rst_q;
   assign dfr_done              = done_q;
   assign error                 = error_q;
   assign sample_index          = sample_index_q;
   assign state_o               = DFR_STATE_W'(state_q);

endmodule
